// File: rtl/ysyx_24120013_imem_responder.sv
// Instruction-memory responder: valid/ready fetch port backed by a word array with a fixed read latency.
// Define IMEM_RAND_DELAY_EN to add 0..3 pseudo-random extra wait cycles per request.
module ysyx_24120013_imem_responder #(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  input  logic                  ld_wen,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Wide enough for LATENCY-1 (max 14) plus up to 3 random extra cycles.
  localparam int          CNT_W = 5;
  localparam logic [32:0] SPAN  = 33'd4 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_en;
  logic [CNT_W-1:0]      cnt_load;

  logic [31:0]           offset;
  logic                  dec_err;
  logic [DEPTH_LOG2-1:0] rd_idx;

  // Offset wraps, so addresses below BASE_ADDR land far above SPAN and fail the range check.
  assign offset  = addr_q - BASE_ADDR;
  assign dec_err = (addr_q[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
  assign rd_idx  = offset[DEPTH_LOG2+1:2];

`ifdef IMEM_RAND_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end

  assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
  assign cnt_load = CNT_W'(LATENCY - 1);
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    rd_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = cnt_load;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rd_en        = !dec_err;
          resp_err_d   = dec_err;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Loader writes ignore reset; the registered read sees the pre-write word on a same-edge collision.
  always_ff @(posedge clk) begin
    if (ld_wen) mem[ld_addr] <= ld_data;
    if (rst)        rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_idx];
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_err_q ? '0 : rd_data_q;

endmodule
